// File: rtl/jtframe_sdram64_cmdarb_pkg.sv
// Shared definitions for the 64-bit SDRAM command-bus arbiter.
// Holds SDRAM command encodings {/CS,/RAS,/CAS,/WE}, the arbiter FSM states,
// the bank count and a one-hot to index helper.
package jtframe_sdram64_cmdarb_pkg;

  localparam int NBANK = 4;

  localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;
  localparam logic [3:0] CMD_REFRESH   = 4'b0001;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] CMD_WRITE     = 4'b0100;
  localparam logic [3:0] CMD_READ      = 4'b0101;
  localparam logic [3:0] CMD_STOP      = 4'b0110;
  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_INHIBIT   = 4'b1000;

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_RFSH  = 2'd2
  } arb_state_t;

  // One-hot bank vector to bank index. An all-zero vector maps to 0.
  function automatic logic [1:0] onehot2idx(input logic [NBANK-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NBANK; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/jtframe_sdram64_rrpick.sv
// Combinational 4-way round-robin picker.
// Ports: req (request mask), last (index of last winner) -> win (one-hot
// winner, first set request after last searching upward mod 4), valid.
module jtframe_sdram64_rrpick
  import jtframe_sdram64_cmdarb_pkg::*;
(
  input  logic [NBANK-1:0] req,
  input  logic [1:0]       last,
  output logic [NBANK-1:0] win,
  output logic             valid
);

  logic [1:0] idx;
  logic       found;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 2'd0;
    // k = 1..4 visits last+1, last+2, last+3 and finally last itself
    for (int k = 1; k <= NBANK; k++) begin
      idx = last + 2'(k);
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/jtframe_sdram64_cmdarb.sv
// SDRAM command-bus arbiter: four bank engines (round-robin, one command per
// grant) and a refresh unit (br/bg/rfshing handshake) share registered pins.
// Ports: bank_br/cmd/a/idle in, bank_bg out; rfsh_br/help/cmd/a/rfshing in,
// rfsh_bg and noreq out; sdram_cmd/ba/a registered pin outputs.
module jtframe_sdram64_cmdarb
  import jtframe_sdram64_cmdarb_pkg::*;
#(
  parameter int AW        = 13,
  parameter bit HELPFIRST = 1'b1
) (
  input  logic              rst,
  input  logic              clk,
  input  logic [3:0]        bank_br,
  input  logic [15:0]       bank_cmd,
  input  logic [4*AW-1:0]   bank_a,
  input  logic [3:0]        bank_idle,
  output logic [3:0]        bank_bg,
  input  logic              rfsh_br,
  input  logic              rfsh_help,
  input  logic [3:0]        rfsh_cmd,
  input  logic [AW-1:0]     rfsh_a,
  input  logic              rfshing,
  output logic              rfsh_bg,
  output logic              noreq,
  output logic [3:0]        sdram_cmd,
  output logic [1:0]        sdram_ba,
  output logic [AW-1:0]     sdram_a
);

  arb_state_t       state, state_nxt;
  logic [1:0]       last;
  logic [3:0]       eligible;
  logic [3:0]       win;
  logic             win_vld;
  logic [1:0]       win_idx;
  logic [3:0]       sel_cmd;
  logic [AW-1:0]    sel_a;
  logic             rfsh_entry;
  logic             grant;
  logic             rfsh_bg_nxt;
  logic [3:0]       cmd_nxt;
  logic [1:0]       ba_nxt;
  logic [AW-1:0]    a_nxt;

  // A requester sees its grant one cycle late and keeps br up for one more
  // sampling edge; masking the bank granted last cycle absorbs that.
  assign eligible = bank_br & ~bank_bg;

  jtframe_sdram64_rrpick u_pick (
    .req   (eligible),
    .last  (last),
    .win   (win),
    .valid (win_vld)
  );

  assign win_idx = onehot2idx(win);

  always_comb begin
    sel_cmd = CMD_NOP;
    sel_a   = '0;
    for (int i = 0; i < NBANK; i++) begin
      if (win[i]) begin
        sel_cmd = bank_cmd[4*i +: 4];
        sel_a   = bank_a[AW*i +: AW];
      end
    end
  end

  assign rfsh_entry = rfsh_br && (!(|bank_br) || (HELPFIRST && rfsh_help));

  always_comb begin
    state_nxt   = state;
    grant       = 1'b0;
    rfsh_bg_nxt = 1'b0;
    cmd_nxt     = CMD_NOP;
    ba_nxt      = sdram_ba;
    a_nxt       = sdram_a;
    case (state)
      ST_ARB: begin
        if (rfsh_entry) begin
          state_nxt = ST_DRAIN;
        end else if (win_vld) begin
          grant   = 1'b1;
          cmd_nxt = sel_cmd;
          a_nxt   = sel_a;
          ba_nxt  = win_idx;
        end
      end
      ST_DRAIN: begin
        if (!rfsh_br) begin
          state_nxt = ST_ARB;
        end else if (&bank_idle) begin
          rfsh_bg_nxt = 1'b1;
          state_nxt   = ST_RFSH;
        end
      end
      ST_RFSH: begin
        // rfshing only rises after the refresh unit sees rfsh_bg, so it is
        // ignored while the grant pulse is still on the wire.
        if (!rfshing && !rfsh_bg) begin
          state_nxt = ST_ARB;
        end else begin
          cmd_nxt = rfsh_cmd;
          a_nxt   = rfsh_a;
          ba_nxt  = 2'd0;
        end
      end
      default: state_nxt = ST_ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_ARB;
      last      <= 2'd3;
      bank_bg   <= '0;
      rfsh_bg   <= 1'b0;
      noreq     <= 1'b1;
      sdram_cmd <= CMD_NOP;
      sdram_ba  <= 2'd0;
      sdram_a   <= '0;
    end else begin
      state     <= state_nxt;
      bank_bg   <= grant ? win : 4'd0;
      rfsh_bg   <= rfsh_bg_nxt;
      noreq     <= ~|bank_br;
      sdram_cmd <= cmd_nxt;
      sdram_ba  <= ba_nxt;
      sdram_a   <= a_nxt;
      if (grant) last <= win_idx;
    end
  end

endmodule

// File: tb/tb_jtframe_sdram64_cmdarb.sv
// Bench for jtframe_sdram64_cmdarb: registered bank requesters and a refresh
// unit model drive the DUT; expected grants go into a scoreboard queue and are
// popped and compared whenever bank_bg pulses.
`timescale 1ns/1ps
module tb_jtframe_sdram64_cmdarb;
  import jtframe_sdram64_cmdarb_pkg::*;

  localparam int AW = 13;
  localparam logic [AW-1:0] A10 = 13'h0400;

  logic            rst, clk;
  logic [3:0]      bank_br, bank_idle, bank_bg;
  logic [15:0]     bank_cmd;
  logic [4*AW-1:0] bank_a;
  logic            rfsh_br, rfsh_help, rfshing, rfsh_bg, noreq;
  logic [3:0]      rfsh_cmd, sdram_cmd;
  logic [AW-1:0]   rfsh_a, sdram_a;
  logic [1:0]      sdram_ba;

  jtframe_sdram64_cmdarb #(.AW(AW), .HELPFIRST(1'b1)) dut (
    .rst(rst), .clk(clk),
    .bank_br(bank_br), .bank_cmd(bank_cmd), .bank_a(bank_a),
    .bank_idle(bank_idle), .bank_bg(bank_bg),
    .rfsh_br(rfsh_br), .rfsh_help(rfsh_help), .rfsh_cmd(rfsh_cmd),
    .rfsh_a(rfsh_a), .rfshing(rfshing), .rfsh_bg(rfsh_bg),
    .noreq(noreq), .sdram_cmd(sdram_cmd), .sdram_ba(sdram_ba),
    .sdram_a(sdram_a)
  );

  typedef struct packed {
    logic [1:0]    idx;
    logic [3:0]    cmd;
    logic [AW-1:0] a;
  } exp_t;

  exp_t          sb[$];
  exp_t          e;
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  int            pend[4];
  int            rseq;
  int            rbg_cnt, n_g, first_g, last_g;
  logic [3:0]    cmd_tab[4];
  logic [AW-1:0] a_tab[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input int b);
    exp_t x;
    x.idx = 2'(b);
    x.cmd = cmd_tab[b];
    x.a   = a_tab[b];
    sb.push_back(x);
  endtask

  task automatic req(input int b, input int n);
    pend[b]    = n;
    bank_br[b] = 1'b1;
  endtask

  // One clock: requesters and refresh unit react to what they saw at the edge.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      bank_br[i] = (pend[i] > 0);
      if (bank_bg[i] && pend[i] > 0) pend[i]--;
    end
    if (rfsh_bg) begin
      rfshing = 1'b1; rfsh_br = 1'b0; rfsh_cmd = CMD_PRECHARGE; rfsh_a = A10; rseq = 1;
    end else if (rseq == 1) begin
      rfsh_cmd = CMD_REFRESH; rseq = 2;
    end else if (rseq == 2) begin
      rfsh_cmd = CMD_NOP; rfsh_a = '0; rfshing = 1'b0; rseq = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; bank_br = '0; bank_idle = '0; rfsh_br = 1'b0; rfsh_help = 1'b0;
    rfsh_cmd = CMD_NOP; rfsh_a = '0; rfshing = 1'b0; rseq = 0;
    for (int i = 0; i < 4; i++) pend[i] = 0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Grant monitor: every bank_bg pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rfsh_bg) rbg_cnt++;
    if (|bank_bg) begin
      n_g++;
      if (n_g == 1) first_g = cyc;
      last_g = cyc;
      if (sb.size() == 0) begin
        chk("unexpected_grant", 32'(bank_bg), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("grant_bg",  32'(bank_bg),   32'(4'b0001 << e.idx));
        chk("grant_cmd", 32'(sdram_cmd), 32'(e.cmd));
        chk("grant_a",   32'(sdram_a),   32'(e.a));
        chk("grant_ba",  32'(sdram_ba),  32'(e.idx));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    cmd_tab = '{CMD_ACTIVE, CMD_READ, CMD_WRITE, CMD_PRECHARGE};
    a_tab   = '{13'h0123, 13'h0456, 13'h0789, 13'h1abc};
    bank_cmd = {cmd_tab[3], cmd_tab[2], cmd_tab[1], cmd_tab[0]};
    bank_a   = {a_tab[3], a_tab[2], a_tab[1], a_tab[0]};
    rbg_cnt = 0; n_g = 0; first_g = 0; last_g = 0;
    rst = 1'b1; bank_br = '0; bank_idle = '0; rfsh_br = 1'b0; rfsh_help = 1'b0;
    rfsh_cmd = CMD_NOP; rfsh_a = '0; rfshing = 1'b0; rseq = 0;
    for (int i = 0; i < 4; i++) pend[i] = 0;

    // reset values
    do_reset();
    chk("rst_bank_bg", 32'(bank_bg), 32'd0);
    chk("rst_rfsh_bg", 32'(rfsh_bg), 32'd0);
    chk("rst_noreq",   32'(noreq),   32'd1);
    chk("rst_cmd",     32'(sdram_cmd), 32'(CMD_NOP));
    chk("rst_ba",      32'(sdram_ba), 32'd0);
    chk("rst_a",       32'(sdram_a),  32'd0);

    // single requester: one grant, one cycle after br, no regrant while br drops
    push_exp(0);
    req(0, 1);
    step();
    chk("t1_bg", 32'(bank_bg), 32'h1);
    chk("t1_noreq_busy", 32'(noreq), 32'd0);
    step();
    chk("t1_bg_masked", 32'(bank_bg), 32'h0);
    step();
    step();
    chk("t1_noreq_idle", 32'(noreq), 32'd1);
    chk("t1_sb_empty", 32'(sb.size()), 32'd0);

    // four continuous requesters: 0,1,2,3,0,1,2,3 back to back
    do_reset();
    n_g = 0;
    for (int k = 0; k < 8; k++) push_exp(k % 4);
    for (int i = 0; i < 4; i++) req(i, 2);
    repeat (10) step();
    chk("t2_grants", 32'(n_g), 32'd8);
    chk("t2_span", 32'(last_g - first_g), 32'd7);
    chk("t2_sb_empty", 32'(sb.size()), 32'd0);

    // refresh without help: bank 2 first, drain, bg once, bank 1 held till after
    do_reset();
    rbg_cnt = 0;
    push_exp(2);
    req(2, 1);
    rfsh_br = 1'b1;
    rfsh_help = 1'b0;
    step();
    chk("t3_bank2_first", 32'(bank_bg), 32'h4);
    step();
    step();
    push_exp(1);
    req(1, 1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t3_drain_bg", 32'(bank_bg), 32'h0);
      chk("t3_drain_rbg", 32'(rfsh_bg), 32'd0);
      chk("t3_drain_nop", 32'(sdram_cmd), 32'(CMD_NOP));
    end
    bank_idle = 4'hf;
    step();
    chk("t3_rfsh_bg", 32'(rfsh_bg), 32'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t3_rfsh_hold_bg", 32'(bank_bg), 32'h0);
    end
    step();
    chk("t3_bank1_after", 32'(bank_bg), 32'h2);
    step();
    chk("t3_rbg_once", 32'(rbg_cnt), 32'd1);
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);

    // help overrides bank requests: drain at once, pins mirror refresh cmds
    do_reset();
    push_exp(0);
    push_exp(3);
    req(0, 1);
    req(3, 1);
    rfsh_br = 1'b1;
    rfsh_help = 1'b1;
    bank_idle = 4'hf;
    step();
    chk("t4_no_grant", 32'(bank_bg), 32'h0);
    chk("t4_drain_nop", 32'(sdram_cmd), 32'(CMD_NOP));
    step();
    chk("t4_rfsh_bg", 32'(rfsh_bg), 32'd1);
    chk("t4_bg_nop", 32'(sdram_cmd), 32'(CMD_NOP));
    step();
    chk("t4_pre_cmd", 32'(sdram_cmd), 32'(CMD_PRECHARGE));
    chk("t4_pre_a", 32'(sdram_a), 32'(A10));
    chk("t4_pre_ba", 32'(sdram_ba), 32'd0);
    chk("t4_rbg_pulse", 32'(rfsh_bg), 32'd0);
    step();
    chk("t4_ref_cmd", 32'(sdram_cmd), 32'(CMD_REFRESH));
    chk("t4_ref_a", 32'(sdram_a), 32'(A10));
    step();
    chk("t4_exit_nop", 32'(sdram_cmd), 32'(CMD_NOP));
    chk("t4_exit_bg", 32'(bank_bg), 32'h0);
    step();
    step();
    step();
    chk("t4_sb_empty", 32'(sb.size()), 32'd0);

    // reset in the middle of a refresh; bank 0 wins again afterwards
    do_reset();
    push_exp(0);
    req(0, 1);
    step();
    step();
    step();
    rfsh_br = 1'b1;
    bank_idle = 4'hf;
    step();
    step();
    chk("t5_rfsh_bg", 32'(rfsh_bg), 32'd1);
    step();
    chk("t5_pre_cmd", 32'(sdram_cmd), 32'(CMD_PRECHARGE));
    rst = 1'b1;
    rfshing = 1'b0; rfsh_br = 1'b0; rseq = 0; rfsh_cmd = CMD_NOP; rfsh_a = '0;
    push_exp(0);
    push_exp(2);
    req(0, 1);
    req(2, 1);
    step();
    chk("t5_rst_cmd", 32'(sdram_cmd), 32'(CMD_NOP));
    chk("t5_rst_bg", 32'(bank_bg), 32'h0);
    chk("t5_rst_rbg", 32'(rfsh_bg), 32'd0);
    chk("t5_rst_noreq", 32'(noreq), 32'd1);
    chk("t5_rst_a", 32'(sdram_a), 32'd0);
    rst = 1'b0;
    step();
    chk("t5_bank0_first", 32'(bank_bg), 32'h1);
    step();
    step();
    step();
    chk("t5_sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
